// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory target for the CPU data-access port. Accepts
//   one load/store at a time over a valid/ready request channel, waits
//   LATENCY cycles, performs the access on a register-array memory and
//   returns the result over a valid/ready response channel. Misaligned or
//   out-of-range addresses are reported through resp_err and never touch
//   memory.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  wait cycles between acceptance and the memory access (0 legal)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset (also clears the memory)
//   req_valid   request present
//   req_ready   responder can accept a request (high only in IDLE)
//   req_addr    byte address; word index is addr[log2(DEPTH)+1:2]
//   req_wdata   store data
//   req_rw      1 = store, 0 = load
//   resp_valid  response present
//   resp_ready  requester accepts the response
//   resp_rdata  load data; 0 for stores and errors
//   resp_err    access was misaligned or out of range
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_rw,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;

    // Request fields captured at acceptance (data path, not reset).
    logic [AW-1:0] index_q;
    logic [31:0]   wdata_q;
    logic          rw_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    // Operands of the access actually performed this cycle.
    logic [AW-1:0] acc_index;
    logic [31:0]   acc_wdata;
    logic          acc_rw;
    logic          acc_err;
    logic          access_now;

    // Out of range when any address bit above the word index is set;
    // equivalent to addr[31:2] >= DEPTH because DEPTH is a power of two.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (|a[31:AW+2]);
    endfunction

    assign req_ready = (state == IDLE);

    // With no wait cycles the access uses the live request in the
    // acceptance cycle; otherwise it uses the captured fields.
    always_comb begin
        if (LATENCY == 0) begin
            acc_index  = req_addr[AW+1:2];
            acc_wdata  = req_wdata;
            acc_rw     = req_rw;
            acc_err    = addr_err(req_addr);
            access_now = (state == IDLE) && req_valid;
        end else begin
            acc_index  = index_q;
            acc_wdata  = wdata_q;
            acc_rw     = rw_q;
            acc_err    = err_q;
            access_now = (state == WAIT) && (count == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        index_q <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        rw_q    <= req_rw;
                        err_q   <= addr_err(req_addr);
                        count   <= CW'((LATENCY > 0) ? LATENCY - 1 : 0);
                        state   <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // The access lands on the same edge that enters RESP, so a
            // following request always observes the completed store.
            if (access_now) begin
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                if (acc_err || acc_rw) begin
                    resp_rdata <= '0;
                end else begin
                    resp_rdata <= mem[acc_index];
                end
                if (!acc_err && acc_rw) begin
                    mem[acc_index] <= acc_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Two instances share clk/reset:
//   index 0: DEPTH=64, LATENCY=2
//   index 1: DEPTH=64, LATENCY=0
// A transaction-level model (word array + per-transaction due time) is
// checked against both instances on every falling edge; directed tests
// additionally pin hand-computed literal values.
module tb_data_mem_responder;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid  [2] = '{1'b0, 1'b0};
    logic        req_ready  [2];
    logic [31:0] req_addr   [2] = '{32'h0, 32'h0};
    logic [31:0] req_wdata  [2] = '{32'h0, 32'h0};
    logic        req_rw     [2] = '{1'b0, 1'b0};
    logic        resp_valid [2];
    logic        resp_ready [2] = '{1'b1, 1'b1};
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_rw(req_rw[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_rw(req_rw[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem  [2][64];
    bit          m_busy [2];
    int          m_due  [2];
    logic [31:0] m_rd   [2];
    bit          m_err  [2];
    bit          m_live [2];
    bit          m_zero [2];

    initial begin
        int          ncyc;
        bit          ev;
        logic [31:0] a;
        bit          e;
        ncyc = 0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_live[d] = 0; m_zero[d] = 0; m_due[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ev = m_busy[d] && (ncyc >= m_due[d]);
                if (m_live[d]) begin
                    chk($sformatf("model_req_ready[d%0d]", d), 32'(req_ready[d]), 32'(!m_busy[d]));
                    chk($sformatf("model_resp_valid[d%0d]", d), 32'(resp_valid[d]), 32'(ev));
                    if (ev || m_zero[d]) begin
                        chk($sformatf("model_rdata[d%0d]", d), resp_rdata[d], m_rd[d]);
                        chk($sformatf("model_err[d%0d]", d), 32'(resp_err[d]), 32'(m_err[d]));
                    end
                end
                if (reset) begin
                    m_live[d] = 1; m_busy[d] = 0; m_zero[d] = 1;
                    m_rd[d] = '0; m_err[d] = 0;
                    for (int i = 0; i < 64; i++) m_mem[d][i] = '0;
                end else if (m_busy[d]) begin
                    if (ev && resp_ready[d]) m_busy[d] = 0;
                end else if (req_valid[d]) begin
                    a = req_addr[d];
                    e = (a % 4 != 0) || (a / 4 >= 64);
                    m_err[d] = e;
                    if (e || req_rw[d]) m_rd[d] = '0;
                    else m_rd[d] = m_mem[d][a / 4];
                    if (!e && req_rw[d]) m_mem[d][a / 4] = req_wdata[d];
                    m_busy[d] = 1;
                    m_zero[d] = 0;
                    m_due[d]  = ncyc + 1 + lat_of(d);
                end
            end
            ncyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a request and wait until it is accepted; acc = accept cycle.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, output int acc);
        int n;
        n = 0;
        acc = -1;
        req_addr[d] = a; req_wdata[d] = wd; req_rw[d] = rw; req_valid[d] = 1'b1;
        while (acc < 0 && n < 50) begin
            @(negedge clk);
            if (req_ready[d] === 1'b1 && !reset) acc = cyc;
            n++;
        end
        chk("accepted", 32'(acc >= 0), 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    // Wait for the response, optionally stalling it for 'hold' cycles.
    task automatic await_resp(input int d, input int hold, output logic [31:0] rd,
                              output logic er, output int lat, output int hs);
        bit got;
        got = 0;
        lat = 0;
        resp_ready[d] = (hold == 0);
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (resp_valid[d] === 1'b1) got = 1;
        end
        chk("resp_seen", 32'(got), 32'd1);
        rd = resp_rdata[d];
        er = resp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[d]), 32'd1);
            chk("hold_rdata", resp_rdata[d], rd);
            chk("hold_err", 32'(resp_err[d]), 32'(er));
            chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            resp_ready[d] = 1'b1;
            @(negedge clk);
        end
        hs = cyc;
        @(posedge clk); #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int          acc, acc2, lat, hs;
        logic [31:0] rd;
        logic        er;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'h0);
        chk("rst_err", 32'(resp_err[0]), 32'd0);
        @(posedge clk); #1;

        // 1: write then read, LATENCY=2
        issue(0, 32'h10, 32'hDEADBEEF, 1'b1, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t1_wr_lat", 32'(lat), 32'd3);
        chk("t1_wr_rdata", rd, 32'h0);
        chk("t1_wr_err", 32'(er), 32'd0);
        issue(0, 32'h10, 32'h0, 1'b0, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t1_rd_lat", 32'(lat), 32'd3);
        chk("t1_rd_rdata", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(er), 32'd0);

        // 2: misaligned read, out-of-range write, word 0 untouched
        issue(0, 32'h12, 32'h0, 1'b0, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t2_mis_err", 32'(er), 32'd1);
        chk("t2_mis_rdata", rd, 32'h0);
        issue(0, 32'h100, 32'hFFFFFFFF, 1'b1, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t2_oor_err", 32'(er), 32'd1);
        chk("t2_oor_rdata", rd, 32'h0);
        issue(0, 32'h0, 32'h0, 1'b0, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t2_word0", rd, 32'h0);
        chk("t2_word0_err", 32'(er), 32'd0);

        // 3: stalled response with a new request held waiting
        issue(0, 32'h20, 32'h12345678, 1'b1, acc);
        await_resp(0, 0, rd, er, lat, hs);
        issue(0, 32'h20, 32'h0, 1'b0, acc);
        req_addr[0] = 32'h10; req_rw[0] = 1'b0; req_valid[0] = 1'b1;
        await_resp(0, 4, rd, er, lat, hs);
        chk("t3_rdata", rd, 32'h12345678);
        issue(0, 32'h10, 32'h0, 1'b0, acc2);
        chk("t3_accept_after_hs", 32'(acc2 - hs), 32'd1);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t3_next_rdata", rd, 32'hDEADBEEF);

        // 6: request during reset is ignored, outputs at reset values
        reset = 1'b1;
        req_addr[0] = 32'h10; req_rw[0] = 1'b0; req_valid[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t6_req_ready", 32'(req_ready[0]), 32'd1);
            chk("t6_resp_valid", 32'(resp_valid[0]), 32'd0);
            chk("t6_rdata", resp_rdata[0], 32'h0);
            chk("t6_err", 32'(resp_err[0]), 32'd0);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_resp", 32'(resp_valid[0]), 32'd0);
        end
        @(posedge clk); #1;
        issue(0, 32'h10, 32'h0, 1'b0, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t6_mem_cleared", rd, 32'h0);

        // 4: reset during WAIT aborts a write
        issue(0, 32'h8, 32'hA5A5A5A5, 1'b1, acc);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_no_resp", 32'(resp_valid[0]), 32'd0);
            chk("t4_req_ready", 32'(req_ready[0]), 32'd1);
        end
        @(posedge clk); #1;
        issue(0, 32'h8, 32'h0, 1'b0, acc);
        await_resp(0, 0, rd, er, lat, hs);
        chk("t4_rdata", rd, 32'h0);

        // 5: LATENCY=0 back-to-back
        issue(1, 32'h4, 32'h1, 1'b1, acc);
        await_resp(1, 0, rd, er, lat, hs);
        chk("t5_wr_lat", 32'(lat), 32'd1);
        chk("t5_wr_rdata", rd, 32'h0);
        issue(1, 32'h4, 32'h0, 1'b0, acc2);
        chk("t5_spacing", 32'(acc2 - acc), 32'd2);
        await_resp(1, 0, rd, er, lat, hs);
        chk("t5_rd_lat", 32'(lat), 32'd1);
        chk("t5_rd_rdata", rd, 32'h1);
        chk("t5_rd_err", 32'(er), 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
